// File: rtl/data_path.sv
`default_nettype none
// ============================================================================
// Module   : data_path
// Purpose  : Single-bus CPU datapath. General registers R0-R15, RA, PC, IR,
//            HI, LO, MDR, MAR, Y, 64-bit Z, an I/O port register and a
//            combinational ALU, all connected through one shared bus.
//            o_bus exposes the shared bus for observation.
// Revision : 1.0 - initial release
// ============================================================================
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [4:0]       ops,
  // bus-drive strobes
  input  logic R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic RAout,  input logic RYout,  input logic RZHIout, input logic RZLOout,
  input  logic PCout,  input logic IRout,  input logic HIout,  input logic LOout,
  input  logic MDRout, input logic MARout, input logic PORTout, input logic Cout,
  input  logic BAout,  input logic rout,
  // register load strobes
  input  logic R0in,   input logic R1in,   input logic R2in,   input logic R3in,
  input  logic R4in,   input logic R5in,   input logic R6in,   input logic R7in,
  input  logic R8in,   input logic R9in,   input logic R10in,  input logic R11in,
  input  logic R12in,  input logic R13in,  input logic R14in,  input logic R15in,
  input  logic RAin,   input logic RYin,   input logic RZin,   input logic PCin,
  input  logic IRin,   input logic HIin,   input logic LOin,   input logic MDRin,
  input  logic MARin,  input logic PORTin, input logic rin,
  // IR field select
  input  logic gra,    input logic grb,    input logic grc,
  // memory / PC control
  input  logic Read,
  input  logic Write,
  input  logic IncPC,
  output logic [WIDTH-1:0] o_bus
);

  localparam logic [7:0] c_width8 = 8'(WIDTH);

  // Register state
  logic [WIDTH-1:0]   r_gpr [16];
  logic [WIDTH-1:0]   r_ra, r_pc, r_ir, r_hi, r_lo, r_mdr, r_mar, r_y, r_port;
  logic [2*WIDTH-1:0] r_z;

  // Select/encode and bus wires
  logic [15:0]        w_r_in_raw, w_r_out_raw, w_r_in, w_r_out, w_dec;
  logic [3:0]         w_sel;
  logic               w_sel_valid, w_ba_zero;
  logic [WIDTH-1:0]   w_bus, w_cval;

  // ALU wires
  logic [WIDTH-1:0]   w_alu_lo, w_alu_hi;
  logic [4:0]         w_shamt;
  logic [7:0]         w_rshamt;
  logic signed [2*WIDTH-1:0] w_ax, w_bx, w_prod;

  logic w_unused;
  assign w_unused = ^{Write, r_ir[WIDTH-1:27]};

  assign w_r_in_raw  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                        R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign w_r_out_raw = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                        R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  // Pick the IR register field named by gra/grb/grc and decode it one-hot
  always_comb begin
    w_sel       = 4'd0;
    w_sel_valid = 1'b1;
    if (gra)      w_sel = r_ir[26:23];
    else if (grb) w_sel = r_ir[22:19];
    else if (grc) w_sel = r_ir[18:15];
    else          w_sel_valid = 1'b0;
    w_dec = w_sel_valid ? (16'd1 << w_sel) : 16'd0;
  end

  assign w_r_in    = w_r_in_raw  | ({16{rin}} & w_dec);
  assign w_r_out   = w_r_out_raw | ({16{rout | BAout}} & w_dec);
  // Base-address read of R0 means "no base": the bus sees zero, not R0
  assign w_ba_zero = BAout & w_dec[0];
  assign w_cval    = {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};

  // Bus mux: lowest-priority sources first so later (higher-priority) ones win
  always_comb begin
    w_bus = '0;
    if (Cout)    w_bus = w_cval;
    if (PORTout) w_bus = r_port;
    if (MARout)  w_bus = r_mar;
    if (MDRout)  w_bus = r_mdr;
    if (LOout)   w_bus = r_lo;
    if (HIout)   w_bus = r_hi;
    if (IRout)   w_bus = r_ir;
    if (PCout)   w_bus = r_pc;
    if (RZLOout) w_bus = r_z[WIDTH-1:0];
    if (RZHIout) w_bus = r_z[2*WIDTH-1:WIDTH];
    if (RYout)   w_bus = r_y;
    if (RAout)   w_bus = r_ra;
    for (int i = 15; i >= 0; i--) begin
      if (w_r_out[i]) w_bus = (i == 0 && w_ba_zero) ? '0 : r_gpr[i];
    end
  end

  assign o_bus = w_bus;

  assign w_shamt  = w_bus[4:0];
  assign w_rshamt = c_width8 - {3'b000, w_shamt};
  assign w_ax     = {{WIDTH{r_y[WIDTH-1]}}, r_y};
  assign w_bx     = {{WIDTH{w_bus[WIDTH-1]}}, w_bus};
  assign w_prod   = w_ax * w_bx;

  // ALU: A is Y, B is the bus; IncPC overrides the operation select
  always_comb begin
    w_alu_lo = '0;
    w_alu_hi = '0;
    if (IncPC) begin
      w_alu_lo = w_bus + 1'b1;
    end else begin
      case (ops)
        5'd0:  w_alu_lo = r_y + w_bus;
        5'd1:  w_alu_lo = r_y - w_bus;
        5'd2:  w_alu_lo = r_y & w_bus;
        5'd3:  w_alu_lo = r_y | w_bus;
        5'd4:  w_alu_lo = r_y >> w_shamt;
        5'd5:  w_alu_lo = $unsigned($signed(r_y) >>> w_shamt);
        5'd6:  w_alu_lo = r_y << w_shamt;
        5'd7:  w_alu_lo = (r_y >> w_shamt) | (r_y << w_rshamt);
        5'd8:  w_alu_lo = (r_y << w_shamt) | (r_y >> w_rshamt);
        5'd9:  {w_alu_hi, w_alu_lo} = w_prod;
        5'd10: begin
          if (w_bus == '0) begin
            w_alu_lo = '1;
            w_alu_hi = r_y;
          end else begin
            w_alu_lo = $unsigned($signed(r_y) / $signed(w_bus));
            w_alu_hi = $unsigned($signed(r_y) % $signed(w_bus));
          end
        end
        5'd11: w_alu_lo = '0 - w_bus;
        5'd12: w_alu_lo = ~w_bus;
        default: w_alu_lo = w_bus;
      endcase
    end
  end

  // Register loads from the bus; clear overrides every load strobe
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_ra   <= '0;
      r_pc   <= '0;
      r_ir   <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_mdr  <= '0;
      r_mar  <= '0;
      r_y    <= '0;
      r_port <= '0;
      r_z    <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_r_in[i]) r_gpr[i] <= w_bus;
      end
      if (RAin)   r_ra   <= w_bus;
      if (PCin)   r_pc   <= w_bus;
      if (IRin)   r_ir   <= w_bus;
      if (HIin)   r_hi   <= w_bus;
      if (LOin)   r_lo   <= w_bus;
      if (MARin)  r_mar  <= w_bus;
      if (RYin)   r_y    <= w_bus;
      if (PORTin) r_port <= w_bus;
      if (RZin)   r_z    <= {w_alu_hi, w_alu_lo};
      if (MDRin)  r_mdr  <= Read ? Mdatain : w_bus;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_path
// Purpose  : Directed self-checking bench for data_path. Register contents
//            are observed by driving them onto the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_path;

  logic        clock, clear, Read, Write, IncPC, rin, rout, BAout, gra, grb, grc;
  logic [31:0] Mdatain, o_bus;
  logic [4:0]  ops;
  logic [15:0] Rin_v, Rout_v;
  logic RAout, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout, MDRout, MARout, PORTout, Cout;
  logic RAin, RYin, RZin, PCin, IRin, HIin, LOin, MDRin, MARin, PORTin;

  int n_cmp = 0;
  int n_err = 0;

  data_path #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .ops(ops),
    .R0out(Rout_v[0]),   .R1out(Rout_v[1]),   .R2out(Rout_v[2]),   .R3out(Rout_v[3]),
    .R4out(Rout_v[4]),   .R5out(Rout_v[5]),   .R6out(Rout_v[6]),   .R7out(Rout_v[7]),
    .R8out(Rout_v[8]),   .R9out(Rout_v[9]),   .R10out(Rout_v[10]), .R11out(Rout_v[11]),
    .R12out(Rout_v[12]), .R13out(Rout_v[13]), .R14out(Rout_v[14]), .R15out(Rout_v[15]),
    .RAout(RAout), .RYout(RYout), .RZHIout(RZHIout), .RZLOout(RZLOout),
    .PCout(PCout), .IRout(IRout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .MARout(MARout), .PORTout(PORTout), .Cout(Cout),
    .BAout(BAout), .rout(rout),
    .R0in(Rin_v[0]),   .R1in(Rin_v[1]),   .R2in(Rin_v[2]),   .R3in(Rin_v[3]),
    .R4in(Rin_v[4]),   .R5in(Rin_v[5]),   .R6in(Rin_v[6]),   .R7in(Rin_v[7]),
    .R8in(Rin_v[8]),   .R9in(Rin_v[9]),   .R10in(Rin_v[10]), .R11in(Rin_v[11]),
    .R12in(Rin_v[12]), .R13in(Rin_v[13]), .R14in(Rin_v[14]), .R15in(Rin_v[15]),
    .RAin(RAin), .RYin(RYin), .RZin(RZin), .PCin(PCin), .IRin(IRin), .HIin(HIin),
    .LOin(LOin), .MDRin(MDRin), .MARin(MARin), .PORTin(PORTin), .rin(rin),
    .gra(gra), .grb(grb), .grc(grc),
    .Read(Read), .Write(Write), .IncPC(IncPC),
    .o_bus(o_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clear = 0; Read = 0; Write = 0; IncPC = 0; rin = 0; rout = 0; BAout = 0;
    gra = 0; grb = 0; grc = 0; Mdatain = '0; ops = '0; Rin_v = '0; Rout_v = '0;
    RAout = 0; RYout = 0; RZHIout = 0; RZLOout = 0; PCout = 0; IRout = 0;
    HIout = 0; LOout = 0; MDRout = 0; MARout = 0; PORTout = 0; Cout = 0;
    RAin = 0; RYin = 0; RZin = 0; PCin = 0; IRin = 0; HIin = 0; LOin = 0;
    MDRin = 0; MARin = 0; PORTin = 0;
  endtask

  // One clock edge with the currently driven strobes, then drop them
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  // Bus check for the out strobes the caller has just driven
  task automatic probe(input string tag, input logic [31:0] exp);
    #1;
    check(tag, o_bus, exp);
    idle();
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  // Y <- a, MDR <- b, then Z <- ALU(Y, MDR) under operation op
  task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    mdr_load(a);
    MDRout = 1; RYin = 1;
    tick();
    mdr_load(b);
    MDRout = 1; ops = op; RZin = 1;
    tick();
  endtask

  initial begin
    idle();
    clear = 1;
    tick();
    PCout = 1;   probe("rst_pc", 32'h0);
    RZLOout = 1; probe("rst_zlo", 32'h0);
    Rout_v[5] = 1; probe("rst_r5", 32'h0);

    // PC increment through Z
    PCout = 1; MARin = 1; IncPC = 1; RZin = 1; LOin = 1;
    tick();
    MARout = 1;  probe("mar0", 32'h0);
    LOout = 1;   probe("lo0", 32'h0);
    RZLOout = 1; probe("zlo_inc", 32'h1);
    RZLOout = 1; PCin = 1;
    tick();
    PCout = 1;   probe("pc1", 32'h1);

    // Instruction fetch and indirect register write via gra+rin
    mdr_load(32'h0A800000);
    MDRout = 1; IRin = 1; Write = 1;
    tick();
    IRout = 1;   probe("ir", 32'h0A800000);
    mdr_load(32'h12345678);
    MDRout = 1; LOin = 1;
    tick();
    gra = 1; rin = 1; LOout = 1;
    tick();
    Rout_v[5] = 1; probe("r5_gra", 32'h12345678);
    Rout_v[4] = 1; probe("r4_hold", 32'h0);
    Rout_v[6] = 1; probe("r6_hold", 32'h0);
    PCout = 1;     probe("pc_hold", 32'h1);
    MDRout = 1; PCout = 1; probe("prio_pc_mdr", 32'h1);

    // ALU operations
    alu_run(32'd7, 32'd3, 5'd0);
    RZLOout = 1; probe("add", 32'd10);
    alu_run(32'd7, 32'd3, 5'd1);
    RZLOout = 1; probe("sub", 32'd4);
    alu_run(32'hFFFFFFFE, 32'd3, 5'd9);
    RZLOout = 1; probe("mul_lo", 32'hFFFFFFFA);
    RZHIout = 1; probe("mul_hi", 32'hFFFFFFFF);
    alu_run(32'd17, 32'd5, 5'd10);
    RZLOout = 1; probe("div_q", 32'd3);
    RZHIout = 1; probe("div_r", 32'd2);
    alu_run(32'd9, 32'd0, 5'd10);
    RZLOout = 1; probe("div0_lo", 32'hFFFFFFFF);
    RZHIout = 1; probe("div0_hi", 32'd9);
    alu_run(32'h1, 32'h1, 5'd7);
    RZLOout = 1; probe("ror", 32'h80000000);
    RZHIout = 1; probe("ror_hi", 32'h0);
    alu_run(32'h80000000, 32'd4, 5'd5);
    RZLOout = 1; probe("shra", 32'hF8000000);
    alu_run(32'h0, 32'd5, 5'd12);
    RZLOout = 1; probe("not", 32'hFFFFFFFA);
    alu_run(32'h0, 32'hCAFE0001, 5'd20);
    RZLOout = 1; probe("pass", 32'hCAFE0001);

    // BAout / rout on R0 (IR Rb field is 0), then Cout sign extension
    mdr_load(32'h0000DEAD);
    MDRout = 1; Rin_v[0] = 1;
    tick();
    grb = 1; BAout = 1; probe("ba_r0", 32'h0);
    grb = 1; rout = 1;  probe("rout_r0", 32'h0000DEAD);
    mdr_load(32'h00040000);
    MDRout = 1; IRin = 1;
    tick();
    Cout = 1; probe("c_neg", 32'hFFFC0000);
    mdr_load(32'h0003FFFF);
    MDRout = 1; IRin = 1;
    tick();
    Cout = 1; probe("c_pos", 32'h0003FFFF);

    // Clear wins over simultaneous loads
    mdr_load(32'h00000033);
    MDRout = 1; Rin_v[3] = 1;
    tick();
    Rout_v[3] = 1; probe("r3_pre", 32'h33);
    clear = 1; MDRout = 1; Rin_v[3] = 1; PCin = 1;
    tick();
    Rout_v[3] = 1; probe("clr_r3", 32'h0);
    PCout = 1;     probe("clr_pc", 32'h0);
    Rout_v[5] = 1; probe("clr_r5", 32'h0);
    MDRout = 1;    probe("clr_mdr", 32'h0);
    RZHIout = 1;   probe("clr_zhi", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
